mdu_sequencer: RTL
==================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the busy duration of mult/multu in cycles.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the busy duration of div/divu in cycles.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-low (0 = reset asserted).
REQ-005 start  input  1  E-stage pulse requesting a mult/multu/div/divu.
REQ-006 MDUCtrl  input  4  E-stage op: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 cancel  input  1  E-stage instruction is flushed by an exception or interrupt this cycle.
REQ-008 srcA  input  32  rs operand, already forwarded.
REQ-009 srcB  input  32  rt operand, already forwarded.
REQ-010 busy  output  1  operation in flight; feeds the hazard unit together with start.
REQ-011 result  output  32  HI when MDUCtrl=MFHI, LO when MDUCtrl=MFLO, otherwise 0.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE, start=1 with a mult/div op and cancel=0 SHALL latch srcA, srcB and the op, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 busy SHALL be 1 in exactly the N cycles following the accepting edge, where N is the loaded cycle count.
REQ-015 The counter SHALL decrement once per cycle in BUSY.
REQ-016 At the edge ending the last busy cycle, the block SHALL write HI/LO and return to IDLE; the new values SHALL be visible on result in the first cycle with busy=0.
REQ-017 mult SHALL compute a signed 64-bit product and multu an unsigned 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
REQ-018 div/divu SHALL set LO = quotient and HI = remainder, signed or unsigned as selected.
REQ-019 For signed division, the quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-020 When the divisor is 0, HI/LO SHALL remain unchanged, and busy SHALL still last DIV_CYCLES.
REQ-021 Signed division 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-022 MTHI/MTLO with cancel=0 and busy=0 SHALL write srcA into HI or LO at the next edge, with single-cycle latency.
REQ-023 The following SHALL be ignored (no state change): start or MTHI/MTLO while busy=1; start with a non-mult/div op; any op with cancel=1.
REQ-024 cancel SHALL qualify only the current E-stage op; an operation already in BUSY SHALL complete unaffected.
REQ-025 result SHALL be combinational from the HI/LO registers and MDUCtrl, with zero latency.

Reset
REQ-026 On reset=0, the block SHALL immediately and asynchronously set state=IDLE, counter=0, busy=0, HI=0, LO=0 and the latched operands to 0.
REQ-027 Reset asserted mid-operation SHALL abort that operation with no HI/LO write.
REQ-028 After reset deassertion, the first start SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the MDUCtrl encodings, the FSM state encoding, and the default MULT_CYCLES/DIV_CYCLES constants, shared with MainController.
REQ-030 The divide datapath SHALL be isolated in one sub-module, mdu_divider, taking operands and a signed flag and returning {remainder, quotient} plus a divide-by-zero flag.
REQ-031 The multiply datapath SHALL stay inline.

Verification
REQ-032 mult, srcA=0xFFFFFFFF, srcB=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, and result under MFHI/MFLO shows these values.
REQ-033 divu 7/2 -> busy high 10 cycles, then LO=3, HI=1; div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 mthi 0x1234 -> next cycle MFHI result=0x1234; then div x/0 -> busy high 10 cycles and HI remains 0x1234.
REQ-035 start=1 with cancel=1 (mult 3*3) -> busy stays 0 and HI/LO are unchanged.
REQ-036 start while busy, and mtlo while busy -> both ignored, and the original result is committed on time.
REQ-037 reset driven 0 in busy cycle 3 of a mult -> busy=0 asynchronously and HI=LO=0; after release, mult 2*3 -> LO=6 after 5 cycles.

Source files
------------

// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU definitions: MDUCtrl op encodings, sequencer FSM states
// and default latencies (also used by MainController).
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic is_mul(
    input logic [3:0] op
  );
    return (op == MDU_MULT) ||
           (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == MDU_DIV) ||
           (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Divide datapath: signed/unsigned 32-bit divide.
// Ports: i_dividend, i_divisor, i_signed -> o_rem_quot {rem,quot}, o_div_zero.
module mdu_divider
  import mdu_sequencer_pkg::*;
(
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_signed,
  output logic [63:0] o_rem_quot,
  output logic        o_div_zero
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_den;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_neg_a = i_signed & i_dividend[31];
  assign w_neg_b = i_signed & i_divisor[31];

  // Magnitudes; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  assign w_mag_a = w_neg_a ? (~i_dividend + 32'd1)
                           : i_dividend;
  assign w_mag_b = w_neg_b ? (~i_divisor + 32'd1)
                           : i_divisor;

  assign o_div_zero = (i_divisor == 32'd0);

  // Keep the divider defined on a zero divisor;
  // the result is discarded in that case.
  assign w_den = o_div_zero ? 32'd1 : w_mag_b;

  assign w_uq = w_mag_a / w_den;
  assign w_ur = w_mag_a % w_den;

  // Truncate toward zero; remainder follows dividend.
  assign w_q = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1)
                                   : w_uq;
  assign w_r = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  assign o_rem_quot = {w_r, w_q};

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle mult/div sequencer with HI/LO registers.
// Ports: clk, reset(n), start, MDUCtrl, cancel, srcA, srcB -> busy, result.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUCtrl,
  input  logic        cancel,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] result
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                               : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  mdu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  mdu_op_e     r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  logic        w_idle;
  logic        w_accept;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_last;
  logic        w_op_mul;
  logic        w_op_sgn;
  logic [63:0] w_ea;
  logic [63:0] w_eb;
  logic [63:0] w_prod;
  logic [63:0] w_div_rq;
  logic        w_div_zero;
  logic        w_mfhi;
  logic        w_mflo;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle & start & ~cancel &
                    (is_mul(MDUCtrl) |
                     is_div(MDUCtrl));
  assign w_mthi   = w_idle & ~cancel &
                    (MDUCtrl == MDU_MTHI);
  assign w_mtlo   = w_idle & ~cancel &
                    (MDUCtrl == MDU_MTLO);
  assign w_last   = (r_cnt == CW'(1));

  // Multiply datapath on the latched operands.
  assign w_op_mul = is_mul(r_op);
  assign w_op_sgn = (r_op == MDU_MULT);
  assign w_ea = {{32{w_op_sgn & r_a[31]}}, r_a};
  assign w_eb = {{32{w_op_sgn & r_b[31]}}, r_b};
  assign w_prod = w_ea * w_eb;

  mdu_divider u_div (
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .i_signed   (r_op == MDU_DIV),
    .o_rem_quot (w_div_rq),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MDU_NONE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= srcA;
            r_b     <= srcB;
            r_op    <= mdu_op_e'(MDUCtrl);
            r_cnt   <= is_mul(MDUCtrl)
                       ? CW'(MULT_CYCLES)
                       : CW'(DIV_CYCLES);
            r_busy  <= 1'b1;
            r_state <= ST_BUSY;
          end else if (w_mthi) begin
            r_hi <= srcA;
          end else if (w_mtlo) begin
            r_lo <= srcA;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            if (w_op_mul) begin
              {r_hi, r_lo} <= w_prod;
            end else if (!w_div_zero) begin
              {r_hi, r_lo} <= w_div_rq;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;

  assign w_mfhi = (MDUCtrl == MDU_MFHI);
  assign w_mflo = (MDUCtrl == MDU_MFLO);

  always_comb begin
    result = '0;
    unique case (1'b1)
      w_mfhi:  result = r_hi;
      w_mflo:  result = r_lo;
      default: result = '0;
    endcase
  end

endmodule
